// File: rtl/rv32i_seq_pkg.sv
// Shared encodings for the multi-cycle RV32I sequencer: state codes,
// PC source selects and the mcause values the sequencer can raise.
package rv32i_seq_pkg;

   typedef enum logic [3:0] {
      ST_RESET  = 4'd0,
      ST_FETCH  = 4'd1,
      ST_IWAIT  = 4'd2,
      ST_DECODE = 4'd3,
      ST_EXEC   = 4'd4,
      ST_DREQ   = 4'd5,
      ST_DWAIT  = 4'd6,
      ST_WB     = 4'd7,
      ST_FENCE  = 4'd8,
      ST_PAUSE  = 4'd9,
      ST_TRAP   = 4'd10
   } seq_state_e;

   localparam logic [1:0] PC_SEL_NEXT   = 2'd0;
   localparam logic [1:0] PC_SEL_TARGET = 2'd1;
   localparam logic [1:0] PC_SEL_TRAP   = 2'd2;
   localparam logic [1:0] PC_SEL_RSVD   = 2'd3;

   localparam logic [3:0] CAUSE_INSN_MISALIGNED  = 4'd0;
   localparam logic [3:0] CAUSE_INSN_ACCESS      = 4'd1;
   localparam logic [3:0] CAUSE_ILLEGAL          = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT       = 4'd3;
   localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] CAUSE_LOAD_ACCESS      = 4'd5;
   localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
   localparam logic [3:0] CAUSE_STORE_ACCESS     = 4'd7;
   localparam logic [3:0] CAUSE_ECALL_M          = 4'd11;

   // Control-unit flags kept from DECODE (plus the EXEC compare result)
   // so that WB and the data phase can be decoded from registers alone.
   typedef struct packed {
      logic reg_write;
      logic mem_read;
      logic mem_write;
      logic branch;
      logic jump;
      logic csr;
      logic taken;
   } seq_flags_t;

   function automatic logic [3:0] data_fault_cause(input logic is_store, input logic misaligned);
      if (misaligned) return is_store ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
      return is_store ? CAUSE_STORE_ACCESS : CAUSE_LOAD_ACCESS;
   endfunction

endpackage

// File: rtl/rv32i_seq_wait_counter.sv
// Wait counter shared by the memory timeouts and the PAUSE stall;
// term flags that the count has reached the limit chosen by the caller.
module rv32i_seq_wait_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             en,
   input  logic [CNT_W-1:0] limit,
   output logic             term
);

   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign term = (cnt_q == limit);

endmodule

// File: rtl/rv32i_core_sequencer.sv
// Multi-cycle control FSM of the non-pipelined RV32I core: one instruction
// in flight, memory handshakes, datapath write enables and trap entry.
module rv32i_core_sequencer
   import rv32i_seq_pkg::*;
#(
   parameter int PAUSE_CYCLES   = 16,
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_W          = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       reg_write,
   input  logic       mem_read,
   input  logic       mem_write,
   input  logic       branch,
   input  logic       jump,
   input  logic       fence,
   input  logic       fence_tso,
   input  logic       pause,
   input  logic       ecall,
   input  logic       ebreak,
   input  logic       csr,
   input  logic       illegal,
   input  logic       branch_taken,
   input  logic       addr_misaligned,
   input  logic       target_misaligned,
   output logic       imem_req,
   input  logic       imem_gnt,
   input  logic       imem_rvalid,
   input  logic       imem_err,
   output logic       dmem_req,
   output logic       dmem_we,
   input  logic       dmem_gnt,
   input  logic       dmem_rvalid,
   input  logic       dmem_err,
   input  logic       dmem_idle,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_sel,
   output logic       rf_we,
   output logic       csr_en,
   output logic       instret,
   output logic       trap_valid,
   output logic [3:0] trap_cause,
   output logic [3:0] state_dbg
);

   localparam logic [CNT_W-1:0] TIMEOUT_LIM = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] PAUSE_LIM   = CNT_W'(PAUSE_CYCLES - 1);

   seq_state_e       state_q, state_d;
   seq_flags_t       flags_q;
   logic [3:0]       cause_q, cause_d;
   logic             cnt_clr, cnt_en, cnt_term;
   logic [CNT_W-1:0] cnt_limit;
   logic             is_mem_op;
   logic             ctrl_xfer;

   assign is_mem_op = flags_q.mem_read | flags_q.mem_write;
   assign ctrl_xfer = flags_q.jump | (flags_q.branch & flags_q.taken);

   // ---------------- state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RESET;
         cause_q <= CAUSE_INSN_MISALIGNED;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
      end else if (state_q == ST_DECODE) begin
         flags_q <= '{reg_write: reg_write, mem_read: mem_read, mem_write: mem_write,
                      branch: branch, jump: jump, csr: csr, taken: 1'b0};
      end else if (state_q == ST_EXEC) begin
         flags_q.taken <= branch_taken;
      end
   end

   // ---------------- next-state logic ----------------
   // cause_d only moves on a transition into TRAP, so trap_cause holds its
   // last value everywhere else.
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      case (state_q)
         ST_RESET: state_d = ST_FETCH;
         ST_FETCH: begin
            if (cnt_term) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_INSN_ACCESS;
            end else if (imem_gnt) begin
               state_d = ST_IWAIT;
            end
         end
         ST_IWAIT: begin
            if (imem_rvalid && !imem_err) begin
               state_d = ST_DECODE;
            end else if (imem_rvalid || cnt_term) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_INSN_ACCESS;
            end
         end
         ST_DECODE: begin
            if (illegal) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_ILLEGAL;
            end else if (ebreak) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_BREAKPOINT;
            end else if (ecall) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_ECALL_M;
            end else if (fence || fence_tso) begin
               state_d = ST_FENCE;
            end else if (pause) begin
               state_d = ST_PAUSE;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (is_mem_op && addr_misaligned) begin
               state_d = ST_TRAP;
               cause_d = data_fault_cause(flags_q.mem_write, 1'b1);
            end else if (is_mem_op) begin
               state_d = ST_DREQ;
            end else if ((flags_q.jump || (flags_q.branch && branch_taken)) && target_misaligned) begin
               state_d = ST_TRAP;
               cause_d = CAUSE_INSN_MISALIGNED;
            end else begin
               state_d = ST_WB;
            end
         end
         ST_DREQ: begin
            if (cnt_term) begin
               state_d = ST_TRAP;
               cause_d = data_fault_cause(flags_q.mem_write, 1'b0);
            end else if (dmem_gnt) begin
               state_d = ST_DWAIT;
            end
         end
         ST_DWAIT: begin
            // A response on the terminal-count cycle still completes normally.
            if (dmem_rvalid && !dmem_err) begin
               state_d = ST_WB;
            end else if (dmem_rvalid || cnt_term) begin
               state_d = ST_TRAP;
               cause_d = data_fault_cause(flags_q.mem_write, 1'b0);
            end
         end
         ST_FENCE: if (dmem_idle) state_d = ST_WB;
         ST_PAUSE: if (cnt_term) state_d = ST_WB;
         ST_WB:    state_d = ST_FETCH;
         ST_TRAP:  state_d = ST_FETCH;
         default:  state_d = ST_RESET;
      endcase
   end

   // ---------------- wait counter control ----------------
   always_comb begin
      cnt_clr   = (state_d != state_q) &&
                  (state_d == ST_FETCH || state_d == ST_DREQ || state_d == ST_PAUSE);
      cnt_en    = (state_q == ST_FETCH) || (state_q == ST_IWAIT) ||
                  (state_q == ST_DREQ)  || (state_q == ST_DWAIT) || (state_q == ST_PAUSE);
      cnt_limit = (state_q == ST_PAUSE) ? PAUSE_LIM : TIMEOUT_LIM;
   end

   rv32i_seq_wait_counter #(
      .CNT_W (CNT_W)
   ) u_wait_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .limit (cnt_limit),
      .term  (cnt_term)
   );

   // ---------------- output decode ----------------
   // ir_we is qualified by a clean response so the IR only loads real data.
   always_comb begin
      imem_req   = 1'b0;
      dmem_req   = 1'b0;
      dmem_we    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      pc_sel     = PC_SEL_NEXT;
      rf_we      = 1'b0;
      csr_en     = 1'b0;
      instret    = 1'b0;
      trap_valid = 1'b0;
      trap_cause = cause_q;
      state_dbg  = state_q;
      case (state_q)
         ST_FETCH: imem_req = 1'b1;
         ST_IWAIT: ir_we = imem_rvalid & ~imem_err;
         ST_DREQ: begin
            dmem_req = 1'b1;
            dmem_we  = flags_q.mem_write;
         end
         ST_WB: begin
            pc_we   = 1'b1;
            instret = 1'b1;
            rf_we   = flags_q.reg_write;
            csr_en  = flags_q.csr;
            pc_sel  = ctrl_xfer ? PC_SEL_TARGET : PC_SEL_NEXT;
         end
         ST_TRAP: begin
            trap_valid = 1'b1;
            pc_we      = 1'b1;
            pc_sel     = PC_SEL_TRAP;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_rv32i_core_sequencer.sv
// Directed bench for rv32i_core_sequencer: a reactive memory/control driver
// plus a queue of expected retire/trap records checked on every pc_we pulse.
module tb_rv32i_core_sequencer;
   import rv32i_seq_pkg::*;

   localparam int PAUSE_N = 3;
   localparam int TO_N    = 8;

   localparam logic [11:0] M_RW   = 12'h001;
   localparam logic [11:0] M_MR   = 12'h002;
   localparam logic [11:0] M_MW   = 12'h004;
   localparam logic [11:0] M_BR   = 12'h008;
   localparam logic [11:0] M_JMP  = 12'h010;
   localparam logic [11:0] M_FEN  = 12'h020;
   localparam logic [11:0] M_TSO  = 12'h040;
   localparam logic [11:0] M_PAU  = 12'h080;
   localparam logic [11:0] M_ECL  = 12'h100;
   localparam logic [11:0] M_EBK  = 12'h200;
   localparam logic [11:0] M_CSR  = 12'h400;
   localparam logic [11:0] M_ILL  = 12'h800;
   localparam logic [3:0]  NO_STOP = 4'hF;

   logic clk = 1'b0;
   logic rst_n;
   logic reg_write, mem_read, mem_write, branch, jump, fence, fence_tso, pause;
   logic ecall, ebreak, csr, illegal, branch_taken, addr_misaligned, target_misaligned;
   logic imem_req, imem_gnt, imem_rvalid, imem_err;
   logic dmem_req, dmem_we, dmem_gnt, dmem_rvalid, dmem_err, dmem_idle;
   logic ir_we, pc_we, rf_we, csr_en, instret, trap_valid;
   logic [1:0] pc_sel;
   logic [3:0] trap_cause, state_dbg;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int g;
   logic [25:0] exp_q[$];
   logic [3:0]  last_cause = 4'd0;
   int   req_cycles, we_cycles, fence_cycles, pause_cycles;
   logic irwe_at_rv;

   rv32i_core_sequencer #(
      .PAUSE_CYCLES   (PAUSE_N),
      .TIMEOUT_CYCLES (TO_N),
      .CNT_W          (8)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .reg_write (reg_write), .mem_read (mem_read), .mem_write (mem_write),
      .branch (branch), .jump (jump), .fence (fence), .fence_tso (fence_tso),
      .pause (pause), .ecall (ecall), .ebreak (ebreak), .csr (csr), .illegal (illegal),
      .branch_taken (branch_taken), .addr_misaligned (addr_misaligned),
      .target_misaligned (target_misaligned),
      .imem_req (imem_req), .imem_gnt (imem_gnt), .imem_rvalid (imem_rvalid), .imem_err (imem_err),
      .dmem_req (dmem_req), .dmem_we (dmem_we), .dmem_gnt (dmem_gnt), .dmem_rvalid (dmem_rvalid),
      .dmem_err (dmem_err), .dmem_idle (dmem_idle),
      .ir_we (ir_we), .pc_we (pc_we), .pc_sel (pc_sel), .rf_we (rf_we), .csr_en (csr_en),
      .instret (instret), .trap_valid (trap_valid), .trap_cause (trap_cause), .state_dbg (state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   // ---------------- scoreboard ----------------
   // Record layout: {cycle[15:0], trap_valid, instret, rf_we, csr_en, pc_sel, trap_cause}
   task automatic push_wb(input int at, input logic rf, input logic ce, input logic [1:0] sel);
      logic [15:0] at16;
      at16 = 16'(at);
      exp_q.push_back({at16, 1'b0, 1'b1, rf, ce, sel, last_cause});
   endtask

   task automatic push_trap(input int at, input logic [3:0] cause);
      logic [15:0] at16;
      at16 = 16'(at);
      exp_q.push_back({at16, 1'b1, 1'b0, 1'b0, 1'b0, 2'd2, cause});
      last_cause = cause;
   endtask

   task automatic clear_inputs();
      {reg_write, mem_read, mem_write, branch, jump, fence, fence_tso, pause} = '0;
      {ecall, ebreak, csr, illegal, branch_taken, addr_misaligned, target_misaligned} = '0;
      {imem_gnt, imem_rvalid, imem_err, dmem_gnt, dmem_rvalid, dmem_err} = '0;
      dmem_idle = 1'b1;
   endtask

   // ---------------- driver ----------------
   // Reacts to state_dbg each cycle like the memories and control unit would.
   task automatic drive(input logic [11:0] c, input int i_lat, input logic i_err,
                        input logic [2:0] ex, input int d_gnt, input int d_lat,
                        input logic d_err, input int idle_low, input logic [3:0] stop_at);
      seq_state_e  st;
      seq_state_e  prev_st;
      int          k;
      int          budget;
      bit          done;
      logic [25:0] obs, e;
      prev_st = ST_RESET;
      k = 0; budget = 0; done = 0;
      req_cycles = 0; we_cycles = 0; fence_cycles = 0; pause_cycles = 0; irwe_at_rv = 1'b0;
      check("start_in_fetch", 32'(state_dbg), 32'(ST_FETCH));
      while (!done) begin
         st = seq_state_e'(state_dbg);
         if (st == prev_st) k++; else k = 0;
         prev_st = st;
         clear_inputs();
         if (4'(st) == stop_at) break;
         case (st)
            ST_FETCH: imem_gnt = 1'b1;
            ST_IWAIT: if (k == i_lat - 1) begin
               imem_rvalid = 1'b1;
               imem_err    = i_err;
            end
            ST_DECODE: begin
               {illegal, csr, ebreak, ecall, pause, fence_tso, fence, jump, branch,
                mem_write, mem_read, reg_write} = c;
               if ((c & (M_FEN | M_TSO)) != 12'h0 && idle_low > 0) dmem_idle = 1'b0;
            end
            ST_EXEC: begin
               {branch_taken, addr_misaligned, target_misaligned} = ex;
               imem_rvalid = 1'b1;
               dmem_rvalid = 1'b1;
            end
            ST_DREQ:  dmem_gnt = (k == d_gnt);
            ST_DWAIT: if (k == d_lat - 1) begin
               dmem_rvalid = 1'b1;
               dmem_err    = d_err;
            end
            ST_FENCE: begin
               dmem_idle = (k >= idle_low - 1);
               fence_cycles++;
            end
            ST_PAUSE: pause_cycles++;
            default: ;
         endcase
         #1;
         if (st == ST_IWAIT && imem_rvalid) irwe_at_rv = ir_we;
         if (dmem_req) req_cycles++;
         if (dmem_we) we_cycles++;
         if (pc_we) begin
            obs = {16'(cyc), trap_valid, instret, rf_we, csr_en, pc_sel, trap_cause};
            check("retire_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("retire_record", 32'(obs), 32'(e));
            end
         end
         if (st == ST_WB || st == ST_TRAP) done = 1;
         budget++;
         if (budget > 300) begin
            n_cmp++;
            n_err++;
            $error("FAIL cycle_budget: observed %0d cycles without retire, limit 300", budget);
            done = 1;
         end
         tick();
      end
      if (stop_at == NO_STOP) begin
         check("queue_drained", 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n = 1'b0;
      clear_inputs();
      repeat (3) tick();
      check("reset_outputs", 32'({imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we,
                                  csr_en, instret, trap_valid, trap_cause, state_dbg}), 32'd0);
      rst_n = 1'b1;
      #1;
      check("release_no_req", 32'(imem_req), 32'd0);
      tick();
      check("first_fetch_req", 32'(imem_req), 32'd1);

      // addi: retire 4 cycles after the fetch grant
      g = cyc; push_wb(g + 4, 1'b1, 1'b0, 2'd0);
      drive(M_RW, 1, 1'b0, 3'b000, 0, 1, 1'b0, 0, NO_STOP);
      check("addi_ir_we", 32'(irwe_at_rv), 32'd1);

      // lw: 2-cycle imem, grant after 3 waits, response 2 cycles after grant
      g = cyc; push_wb(g + 11, 1'b1, 1'b0, 2'd0);
      drive(M_RW | M_MR, 2, 1'b0, 3'b000, 3, 2, 1'b0, 0, NO_STOP);
      check("lw_req_cycles", 32'(req_cycles), 32'd4);
      check("lw_we_cycles", 32'(we_cycles), 32'd0);

      // misaligned sw traps without touching dmem
      g = cyc; push_trap(g + 4, 4'd6);
      drive(M_MW, 1, 1'b0, 3'b010, 0, 1, 1'b0, 0, NO_STOP);
      check("sw_mis_no_req", 32'(req_cycles), 32'd0);

      g = cyc; push_wb(g + 6, 1'b0, 1'b0, 2'd0);
      drive(M_MW, 1, 1'b0, 3'b000, 0, 1, 1'b0, 0, NO_STOP);
      check("sw_we_cycles", 32'(we_cycles), 32'd1);

      g = cyc; push_wb(g + 4, 1'b1, 1'b0, 2'd1);                  // jal
      drive(M_RW | M_JMP, 1, 1'b0, 3'b000, 0, 1, 1'b0, 0, NO_STOP);
      g = cyc; push_trap(g + 4, 4'd0);                            // taken, bad target
      drive(M_BR, 1, 1'b0, 3'b101, 0, 1, 1'b0, 0, NO_STOP);
      g = cyc; push_wb(g + 4, 1'b0, 1'b0, 2'd0);                  // not taken, bad target ignored
      drive(M_BR, 1, 1'b0, 3'b001, 0, 1, 1'b0, 0, NO_STOP);
      g = cyc; push_wb(g + 4, 1'b0, 1'b0, 2'd1);                  // taken, aligned
      drive(M_BR, 1, 1'b0, 3'b100, 0, 1, 1'b0, 0, NO_STOP);
      g = cyc; push_wb(g + 4, 1'b1, 1'b1, 2'd0);                  // csrrw
      drive(M_RW | M_CSR, 1, 1'b0, 3'b000, 0, 1, 1'b0, 0, NO_STOP);

      // fetch timeout, then a response landing on the terminal count
      g = cyc; push_trap(g + TO_N, 4'd1);
      drive(M_RW, 100, 1'b0, 3'b000, 0, 1, 1'b0, 0, NO_STOP);
      g = cyc; push_wb(g + TO_N + 2, 1'b1, 1'b0, 2'd0);
      drive(M_RW, TO_N - 1, 1'b0, 3'b000, 0, 1, 1'b0, 0, NO_STOP);

      // decode priority
      g = cyc; push_trap(g + 3, 4'd2);
      drive(M_ILL | M_EBK, 1, 1'b0, 3'b000, 0, 1, 1'b0, 0, NO_STOP);
      g = cyc; push_trap(g + 3, 4'd3);
      drive(M_EBK | M_ECL, 1, 1'b0, 3'b000, 0, 1, 1'b0, 0, NO_STOP);
      g = cyc; push_trap(g + 3, 4'd11);
      drive(M_ECL | M_FEN, 1, 1'b0, 3'b000, 0, 1, 1'b0, 0, NO_STOP);

      // fence: dmem_idle low for 10 cycles starting in DECODE
      g = cyc; push_wb(g + 13, 1'b0, 1'b0, 2'd0);
      drive(M_FEN, 1, 1'b0, 3'b000, 0, 1, 1'b0, 10, NO_STOP);
      check("fence_cycles", 32'(fence_cycles), 32'd10);
      g = cyc; push_wb(g + 4, 1'b0, 1'b0, 2'd0);
      drive(M_TSO | M_PAU, 1, 1'b0, 3'b000, 0, 1, 1'b0, 0, NO_STOP);

      g = cyc; push_wb(g + 3 + PAUSE_N, 1'b0, 1'b0, 2'd0);
      drive(M_PAU, 1, 1'b0, 3'b000, 0, 1, 1'b0, 0, NO_STOP);
      check("pause_cycles", 32'(pause_cycles), 32'(PAUSE_N));

      // bus errors and data-side faults
      g = cyc; push_trap(g + 2, 4'd1);
      drive(M_RW, 1, 1'b1, 3'b000, 0, 1, 1'b0, 0, NO_STOP);
      check("ifetch_err_no_ir_we", 32'(irwe_at_rv), 32'd0);
      g = cyc; push_trap(g + 6, 4'd5);
      drive(M_RW | M_MR, 1, 1'b0, 3'b000, 0, 1, 1'b1, 0, NO_STOP);
      g = cyc; push_trap(g + 6, 4'd7);
      drive(M_MW, 1, 1'b0, 3'b000, 0, 1, 1'b1, 0, NO_STOP);
      g = cyc; push_trap(g + 4, 4'd4);
      drive(M_RW | M_MR, 1, 1'b0, 3'b010, 0, 1, 1'b0, 0, NO_STOP);
      g = cyc; push_trap(g + 4 + TO_N, 4'd5);
      drive(M_RW | M_MR, 1, 1'b0, 3'b000, 100, 1, 1'b0, 0, NO_STOP);
      check("dtimeout_req_cycles", 32'(req_cycles), 32'(TO_N));

      // asynchronous reset while a load waits for its response
      drive(M_RW | M_MR, 1, 1'b0, 3'b000, 0, 5, 1'b0, 0, 4'(ST_DWAIT));
      check("in_dwait", 32'(state_dbg), 32'(ST_DWAIT));
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_outputs", 32'({imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel, rf_we,
                                        csr_en, instret, trap_valid, trap_cause, state_dbg}), 32'd0);
      last_cause = 4'd0;
      tick();
      rst_n = 1'b1;
      #1;
      check("rerelease_no_req", 32'(imem_req), 32'd0);
      tick();
      check("rerelease_fetch_req", 32'(imem_req), 32'd1);

      g = cyc; push_wb(g + 4, 1'b1, 1'b0, 2'd0);
      drive(M_RW, 1, 1'b0, 3'b000, 0, 1, 1'b0, 0, NO_STOP);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
